// File: rtl/mac_pkg.sv
// Shared constants, FSM state type and lane helper for the MAC array partial-sum path.
package mac_pkg;

  localparam int N_FILT  = 40;
  localparam int PSUM_W  = 22;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int GRP_W   = 8;
  localparam int FID_W   = 6;
  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic signed [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
    return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Result stream towards the feature-map writer: one 8-bit value per filter, valid/ready.
interface psum_collector_if;
  import mac_pkg::*;

  logic [OUT_W-1:0] dout;
  logic [FID_W-1:0] dout_fid;
  logic             dout_vld;
  logic             dout_rdy;

  modport master (output dout, output dout_fid, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_fid, input dout_vld, output dout_rdy);

endinterface

// File: rtl/psum_requant.sv
// Combinational requantiser: ReLU, arithmetic right shift, clamp to the unsigned output range.
// Zero latency; no handshake of its own.
module psum_requant
  import mac_pkg::*;
(
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [OUT_W-1:0]   q
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> shift;
    if (acc[ACC_W-1]) begin
      q = '0;
    end else if (|shifted[ACC_W-1:OUT_W]) begin
      q = '1;
    end else begin
      q = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Accumulates per-filter partial sums over num_grp beats, then streams 40 requantised results.
// dout_vld rises one cycle after the last beat; dout/dout_fid hold while dout_rdy is low.
module psum_collector
  import mac_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [GRP_W-1:0]           num_grp,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic [PSUM_W*N_FILT-1:0]   psum_i,
  input  logic [N_FILT-1:0]          psum_vld_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  psum_collector_if.master           dout_if
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [N_FILT];
  logic [GRP_W-1:0]        grp_cnt_q;
  logic [GRP_W-1:0]        num_grp_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic [FID_W-1:0]        fid_q;
  logic                    done_q;
  logic                    err_q;

  logic                    beat_all;
  logic                    beat_any;
  logic                    accept;
  logic                    last_beat;
  logic                    xfer;
  logic                    last_xfer;
  logic [OUT_W-1:0]        q;

  assign beat_all  = &psum_vld_i;
  assign beat_any  = |psum_vld_i;
  assign accept    = (state_q == ACCUM) && beat_all;
  assign last_beat = accept && (grp_cnt_q == num_grp_q - GRP_W'(1));
  assign xfer      = (state_q == DRAIN) && dout_if.dout_rdy;
  assign last_xfer = xfer && (fid_q == FID_W'(N_FILT-1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_FILT; k++) acc_q[k] <= '0;
      grp_cnt_q <= '0;
      num_grp_q <= GRP_W'(1);
      shift_q   <= '0;
      fid_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_grp_q <= (num_grp == '0) ? GRP_W'(1) : num_grp;
            shift_q   <= shift;
            grp_cnt_q <= '0;
            err_q     <= 1'b0;
            for (int k = 0; k < N_FILT; k++) acc_q[k] <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int k = 0; k < N_FILT; k++) begin
              acc_q[k] <= acc_q[k] + sext_psum(psum_i[PSUM_W*k +: PSUM_W]);
            end
            grp_cnt_q <= grp_cnt_q + GRP_W'(1);
            if (last_beat) fid_q <= '0;
          end else if (beat_any) begin
            // lanes out of step: the whole beat is unusable
            err_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (beat_any) err_q <= 1'b1;
          if (xfer) begin
            fid_q <= last_xfer ? '0 : fid_q + FID_W'(1);
            if (last_xfer) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  psum_requant u_requant (
    .acc   (acc_q[fid_q]),
    .shift (shift_q),
    .q     (q)
  );

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign dout_if.dout_vld = (state_q == DRAIN);
  assign dout_if.dout     = (state_q == DRAIN) ? q : '0;
  assign dout_if.dout_fid = fid_q;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: table of uniform-lane pixels plus hand-written corner sequences.
module tb_psum_collector;
  import mac_pkg::*;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     start = 1'b0;
  logic [GRP_W-1:0]         num_grp = '0;
  logic [SHIFT_W-1:0]       shift = '0;
  logic [PSUM_W*N_FILT-1:0] psum_i = '0;
  logic [N_FILT-1:0]        psum_vld_i = '0;
  logic                     busy_o, done_o, err_o;
  logic                     toggle_rdy = 1'b0;
  logic                     rdy_force = 1'b1;
  logic                     tog = 1'b0;

  psum_collector_if dif ();
  assign dif.dout_rdy = toggle_rdy ? tog : rdy_force;

  psum_collector dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_grp    (num_grp),
    .shift      (shift),
    .psum_i     (psum_i),
    .psum_vld_i (psum_vld_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .dout_if    (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  typedef struct { int fid; int val; } exp_t;
  typedef struct { int ng; int sh; int val; int exp; } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   beat_vals [4][N_FILT];
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model(input longint acc, input int sh);
    longint v;
    if (acc < 0) return 0;
    v = acc >>> sh;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic fill(input int b, input int val);
    for (int k = 0; k < N_FILT; k++) beat_vals[b][k] = val;
  endtask

  task automatic monitor();
    logic             held;
    logic [OUT_W-1:0] hd;
    logic [FID_W-1:0] hf;
    exp_t             e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && dif.dout_vld) begin
        if (held) begin
          chk("hold_dout", 64'(dif.dout), 64'(hd));
          chk("hold_fid", 64'(dif.dout_fid), 64'(hf));
        end
        if (dif.dout_rdy) begin
          held = 1'b0;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xfer: got fid %0d with no result expected", dif.dout_fid);
          end else begin
            e = sbq.pop_front();
            chk("dout", 64'(dif.dout), 64'(e.val));
            chk("dout_fid", 64'(dif.dout_fid), 64'(e.fid));
          end
        end else begin
          held = 1'b1;
          hd   = dif.dout;
          hf   = dif.dout_fid;
        end
      end else begin
        held = 1'b0;
      end
    end
  endtask

  task automatic do_start(input int ng, input int sh);
    @(posedge clk); #1;
    num_grp = GRP_W'(ng);
    shift   = SHIFT_W'(sh);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'(1));
    chk("err_after_start", 64'(err_o), 64'(0));
  endtask

  task automatic drive_beat(input logic [N_FILT-1:0] vld, input int b);
    @(posedge clk); #1;
    for (int k = 0; k < N_FILT; k++) psum_i[PSUM_W*k +: PSUM_W] = PSUM_W'(beat_vals[b][k]);
    psum_vld_i = vld;
  endtask

  task automatic run_beats(input int nbeats, input int sh, input int tbl_exp);
    longint acc [N_FILT];
    exp_t   e;
    for (int k = 0; k < N_FILT; k++) acc[k] = 0;
    for (int b = 0; b < nbeats; b++) begin
      drive_beat({N_FILT{1'b1}}, b);
      chk("vld_early", 64'(dif.dout_vld), 64'(0));
      for (int k = 0; k < N_FILT; k++) acc[k] += beat_vals[b][k];
    end
    @(posedge clk); #1;
    psum_vld_i = '0;
    chk("vld_rise", 64'(dif.dout_vld), 64'(1));
    for (int k = 0; k < N_FILT; k++) begin
      e.fid = k;
      e.val = (tbl_exp >= 0) ? tbl_exp : model(acc[k], sh);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 3000);
    chk("done_seen", 64'(done_o), 64'(1));
    chk("done_vld_low", 64'(dif.dout_vld), 64'(0));
    chk("busy_at_done", 64'(busy_o), 64'(0));
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    if (exp_n > 0) chk("done_latency", 64'(n), 64'(exp_n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb;
    fork
      monitor();
    join_none

    tbl[0] = '{1, 0, 7, 7};
    tbl[1] = '{3, 1, -7, 0};
    tbl[2] = '{2, 3, 1000, 250};
    tbl[3] = '{1, 0, 256, 255};
    tbl[4] = '{1, 1, 511, 255};
    tbl[5] = '{2, 4, 4096, 255};

    #2;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_vld", 64'(dif.dout_vld), 64'(0));
    chk("rst_dout", 64'(dif.dout), 64'(0));
    chk("rst_fid", 64'(dif.dout_fid), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].ng, tbl[i].sh);
      nb = (tbl[i].ng == 0) ? 1 : tbl[i].ng;
      for (int b = 0; b < nb; b++) fill(b, tbl[i].val);
      run_beats(nb, tbl[i].sh, tbl[i].exp);
      wait_done(41);
    end

    // basic pixel: lane k = 3k, then done is a single-cycle pulse
    do_start(1, 0);
    for (int k = 0; k < N_FILT; k++) beat_vals[0][k] = 3 * k;
    run_beats(1, 0, -1);
    wait_done(41);
    @(negedge clk);
    chk("done_pulse_end", 64'(done_o), 64'(0));
    chk("basic_err", 64'(err_o), 64'(0));

    // four groups with toggling ready
    toggle_rdy = 1'b1;
    do_start(4, 2);
    for (int b = 0; b < 4; b++) fill(b, 100);
    run_beats(4, 2, -1);
    wait_done(0);
    toggle_rdy = 1'b0;

    // ReLU and saturation on the first three lanes
    do_start(2, 0);
    fill(0, 0);
    fill(1, 0);
    beat_vals[0][0] = -50;       beat_vals[1][0] = -50;
    beat_vals[0][1] = 2000;      beat_vals[1][1] = 2000;
    beat_vals[0][2] = -(1 << 21); beat_vals[1][2] = (1 << 21) - 1;
    run_beats(2, 0, -1);
    wait_done(41);

    // overrun during a stalled drain, then reset mid-drain
    @(negedge clk);
    rdy_force = 1'b0;
    do_start(1, 0);
    fill(0, 9);
    run_beats(1, 0, -1);
    repeat (3) @(posedge clk);
    drive_beat({N_FILT{1'b1}}, 0);
    @(posedge clk); #1;
    psum_vld_i = '0;
    chk("overrun_err", 64'(err_o), 64'(1));
    chk("overrun_dout", 64'(dif.dout), 64'(9));
    chk("overrun_fid", 64'(dif.dout_fid), 64'(0));
    chk("overrun_vld", 64'(dif.dout_vld), 64'(1));
    rstn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_vld", 64'(dif.dout_vld), 64'(0));
    chk("midrst_dout", 64'(dif.dout), 64'(0));
    chk("midrst_err", 64'(err_o), 64'(0));
    sbq.delete();
    @(negedge clk);
    rstn      = 1'b1;
    rdy_force = 1'b1;

    // misaligned beat is dropped and flagged
    do_start(2, 0);
    fill(0, 1);
    drive_beat(40'h7F_FFFF_FFFF, 0);
    @(posedge clk); #1;
    psum_vld_i = '0;
    chk("misalign_err", 64'(err_o), 64'(1));
    chk("misalign_busy", 64'(busy_o), 64'(1));
    fill(0, 1);
    fill(1, 1);
    run_beats(2, 0, -1);
    wait_done(41);
    chk("err_sticky", 64'(err_o), 64'(1));

    // start in the done cycle; num_grp 0 behaves as 1
    num_grp = '0;
    shift   = '0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy_o), 64'(1));
    chk("b2b_err_cleared", 64'(err_o), 64'(0));
    fill(0, 5);
    run_beats(1, 0, -1);
    wait_done(41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
